// File: rtl/mult_control_if.sv
// Handshake and data bundle between a requester, the iteration counter and
// the shift-add multiplier controller.
interface mult_control_if #(
    parameter int WIDTH = 8
);
    logic               Start;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               K;
    logic               Load;
    logic               Busy;
    logic               Done;
    logic [2*WIDTH-1:0] Product;

    // Requester side: drives operands, start request and the counter flag.
    modport master (
        output Start, A, B, K,
        input  Load, Busy, Done, Product
    );

    // Multiplier controller side.
    modport slave (
        input  Start, A, B, K,
        output Load, Busy, Done, Product
    );
endinterface

// File: rtl/mult_control.sv
// Sequential shift-add unsigned multiplier controller.
// One iteration per CALC cycle; an external counter (cleared by Load)
// raises K on the last iteration. Product is registered on DONE entry.
module mult_control #(
    parameter int WIDTH = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    mult_control_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_next_s;

    logic [WIDTH-1:0]     m_r;
    logic [WIDTH-1:0]     lo_r;
    logic [WIDTH:0]       hi_r;
    logic [2*WIDTH-1:0]   product_r;

    logic                 load_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 load_next_s;
    logic                 busy_next_s;
    logic                 done_next_s;

    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       hi_shift_s;
    logic [WIDTH-1:0]     lo_shift_s;

    // One shift-add iteration: conditional add of M into Hi, then shift {Hi,Lo} right.
    always_comb begin
        sum_s      = hi_r;
        hi_shift_s = {(WIDTH+1){1'b0}};
        lo_shift_s = {WIDTH{1'b0}};
        if (lo_r[0]) begin
            sum_s = {1'b0, hi_r[WIDTH-1:0]} + {1'b0, m_r};
        end else begin
            sum_s = hi_r;
        end
        hi_shift_s = {1'b0, sum_s[WIDTH:1]};
        lo_shift_s = {sum_s[0], lo_r[WIDTH-1:1]};
    end

    // Next-state logic and decode of the outputs for the state being entered.
    always_comb begin
        state_next_s = state_r;
        load_next_s  = 1'b0;
        busy_next_s  = 1'b0;
        done_next_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_next_s = ST_CALC;
            end
            ST_CALC: begin
                if (bus.K) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_DONE: begin
                // Start is deliberately not sampled here.
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        case (state_next_s)
            ST_IDLE: begin
                load_next_s = 1'b1;
            end
            ST_LOAD: begin
                load_next_s = 1'b1;
                busy_next_s = 1'b1;
            end
            ST_CALC: begin
                busy_next_s = 1'b1;
            end
            ST_DONE: begin
                done_next_s = 1'b1;
            end
            default: begin
                load_next_s = 1'b1;
            end
        endcase
    end

    // State register and registered state-decoded outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            load_r  <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            load_r  <= load_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    // Datapath: operand capture, accumulator clear, iterations and product load.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            m_r       <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            hi_r      <= {(WIDTH+1){1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.Start) begin
                        m_r  <= bus.A;
                        lo_r <= bus.B;
                    end
                end
                ST_LOAD: begin
                    hi_r <= {(WIDTH+1){1'b0}};
                end
                ST_CALC: begin
                    hi_r <= hi_shift_s;
                    lo_r <= lo_shift_s;
                    // Last iteration: capture the post-shift result as DONE is entered.
                    if (bus.K) begin
                        product_r <= {hi_shift_s[WIDTH-1:0], lo_shift_s};
                    end
                end
                ST_DONE: begin
                    hi_r <= hi_r;
                end
                default: begin
                    hi_r <= hi_r;
                end
            endcase
        end
    end

    assign bus.Load    = load_r;
    assign bus.Busy    = busy_r;
    assign bus.Done    = done_r;
    assign bus.Product = product_r;

endmodule

// File: doc/mult_control.md
MULT_CONTROL -- requirements
Module: mult_control

Interface
REQ-001 Parameter: WIDTH, default 8, operand width; SHALL be 8, since the companion Counter asserts K on the 8th iteration.
REQ-002 Port: Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset.
REQ-004 Port: Start  input  1  request a multiplication; sampled only in IDLE.
REQ-005 Port: A  input  8  multiplicand; captured on the accepting edge.
REQ-006 Port: B  input  8  multiplier; captured on the accepting edge.
REQ-007 Port: K  input  1  from Counter; high means the current CALC cycle is the last iteration.
REQ-008 Port: Load  output  1  to Counter Load; clears the iteration count.
REQ-009 Port: Busy  output  1  high while in LOAD or CALC.
REQ-010 Port: Done  output  1  one-cycle completion pulse.
REQ-011 Port: Product  output  16  registered result of A*B, unsigned.

Function
REQ-012 The FSM SHALL use exactly four states: IDLE, LOAD, CALC and DONE.
REQ-013 IDLE SHALL go to LOAD when Start=1 and SHALL stay in IDLE otherwise; A and B are latched into internal M and Lo on that edge.
REQ-014 LOAD SHALL last one cycle, clear the 9-bit accumulator Hi to 0, and go to CALC.
REQ-015 In every CALC cycle, one iteration SHALL execute: if Lo[0]=1, then Hi = Hi[7:0] + M (9-bit, carry kept); then {Hi,Lo} shifts right by one bit, with 0 entering Hi[8].
REQ-016 CALC SHALL go to DONE on the edge that ends a cycle with K=1; otherwise it stays in CALC.
REQ-017 On entry to DONE, Product SHALL load {Hi[7:0],Lo}; Product holds that value until the next DONE entry or reset.
REQ-018 DONE SHALL last one cycle with Done=1 and then go to IDLE; Start is not sampled in DONE.
REQ-019 Load SHALL be the decode of state in {IDLE, LOAD}: high in IDLE/LOAD, low in CALC/DONE.
- Effect: the counter is held clear while idle and begins counting on the first CALC edge, so K is high in the 8th CALC cycle.
REQ-020 Busy SHALL be the decode of state in {LOAD, CALC}; Done SHALL be the decode of state == DONE.
REQ-021 Latency: Start sampled at edge E0 gives Busy high from E0 to E9 and Done high from E9 to E10; Product is valid from E9.
REQ-022 Start while Busy or Done is high SHALL be ignored, not queued.
REQ-023 A and B changes after the accepting edge SHALL NOT affect the result.
REQ-024 K=1 in IDLE, LOAD or DONE SHALL be ignored.
REQ-025 Arithmetic is unsigned; the full 16-bit product SHALL be produced with no overflow, and 0xFF*0xFF = 0xFE01.
REQ-026 Start may be held high continuously; a new operation then begins on the first IDLE edge after DONE, so the back-to-back period is 11 cycles.

Reset
REQ-027 With Reset=1 at a rising edge, state SHALL become IDLE and Product, Hi, Lo and M SHALL become 0.
REQ-028 Reset SHALL take priority over Start and K in all states, including mid-CALC; the aborted operation produces no Done and does not update Product.
REQ-029 After reset, outputs SHALL be Load=1, Busy=0, Done=0, Product=0x0000.

Verification
REQ-030 The bench SHALL pair this block with the real Counter driven by Load, and cover these directed scenarios:
- A=0x0D, B=0x0B, Start pulse at E0 -> Done high only in cycle E9-E10, Product=0x008F, Busy high for exactly 9 cycles.
- A=0xFF, B=0xFF -> Product=0xFE01; then A=0x00, B=0xFF -> Product=0x0000.
- Start re-pulsed at E3 and E8 of an operation, A/B changed at E2 -> single Done at E9, result from the original operands.
- Reset asserted in the 4th CALC cycle -> IDLE next edge, Product=0x0000, no Done; next Start with 0x02*0x03 -> Product=0x0006.
- Start held high for 30 cycles with A=0x10, B=0x10 -> Done pulses at E9, E20 and E31 (11-cycle period), Product=0x0100.
- K forced high while idle, then a normal 0x07*0x09 operation -> no early Done, Product=0x003F.
